// File: rtl/nes_pkg.sv
// Shared constants and state encoding for the sprite-DMA bus arbiter.
package nes_pkg;

  localparam logic [15:0] SPRDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALT  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/bus_cyc_timer.sv
// Loadable down-counter timing one bus segment (HALT, READ or WRITE).
// o_tc is high while the count sits at zero, i.e. on the last clock of a segment.
module bus_cyc_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count down while enabled; a load restarts the segment at its terminal value.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every register so all flops update from the same pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sprdma_arb.sv
// Bus arbiter and sprite-DMA sequencer: passes CPU cycles through, and on a
// CPU write to $4014 stalls the CPU and copies page $NN00-$NNFF to $2004.
module sprdma_arb
  import nes_pkg::*;
#(
  parameter int CYC_CLKS  = 4,
  parameter int HALT_CLKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_in,
  input  logic [15:0] cpu_a,
  input  logic        cpu_r_nw,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_a,
  output logic        bus_r_nw,
  output logic [7:0]  bus_dout,
  output logic        dma_active
);

  localparam logic [3:0] CYC_TC  = 4'(CYC_CLKS - 1);
  localparam logic [3:0] HALT_TC = 4'(HALT_CLKS - 1);

  dma_state_e  r_state, w_next_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_page;
  logic [7:0]  r_data;
  logic        r_q_hit;

  logic        w_hit, w_start, w_tc, w_seg_end;
  logic        w_load;
  logic [3:0]  w_load_val;

  assign w_hit     = (cpu_a == SPRDMA_ADDR) && !cpu_r_nw;
  assign w_start   = w_hit && !r_q_hit;
  assign w_seg_end = w_tc && ready_in;

  bus_cyc_timer #(.W(4)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (ready_in),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Next-state and segment-timer reload decisions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = CYC_TC;
    case (r_state)
      IDLE: if (w_start && ready_in) begin
        w_next_state = HALT;
        w_load       = 1'b1;
        w_load_val   = HALT_TC;
      end
      HALT: if (w_seg_end) begin
        w_next_state = READ;
        w_load       = 1'b1;
      end
      READ: if (w_seg_end) begin
        w_next_state = WRITE;
        w_load       = 1'b1;
      end
      WRITE: if (w_seg_end) begin
        if (r_cnt == 8'hFF) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = READ;
          w_load       = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Start edge detector and page latch; evaluated even while ready_in is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_hit <= 1'b0;
      r_page  <= 8'h00;
    end else begin
      r_q_hit <= w_hit;
      if ((r_state == IDLE) && w_start) r_page <= cpu_dout;
    end
  end

  // Byte counter and data latch, advanced only on the last clock of a segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 8'h00;
      r_data <= 8'h00;
    end else begin
      if ((r_state == READ) && w_seg_end)  r_data <= bus_din;
      if ((r_state == WRITE) && w_seg_end) r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Bus mux: CPU passthrough unless the DMA is in a READ or WRITE cycle.
  always_comb begin
    bus_a    = cpu_a;
    bus_r_nw = cpu_r_nw;
    bus_dout = cpu_dout;
    case (r_state)
      READ: begin
        bus_a    = {r_page, r_cnt};
        bus_r_nw = 1'b1;
        bus_dout = r_data;
      end
      WRITE: begin
        bus_a    = OAMDATA_ADDR;
        bus_r_nw = 1'b0;
        bus_dout = r_data;
      end
      default: ;
    endcase
  end

  assign cpu_ready  = ready_in && (r_state == IDLE);
  assign dma_active = (r_state != IDLE);

endmodule

// File: tb/tb_sprdma_arb.sv
// Self-checking bench for sprdma_arb: passthrough table, then DMA sequences
// checked against a read-address/write-data scoreboard.
module tb_sprdma_arb;

  localparam int CYC     = 4;
  localparam int HALT    = 2;
  localparam int DMA_LEN = HALT + 512 * CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_in;
  logic [15:0] cpu_a;
  logic        cpu_r_nw;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [7:0]  bus_din;
  logic [15:0] bus_a;
  logic        bus_r_nw;
  logic [7:0]  bus_dout;
  logic        dma_active;

  sprdma_arb #(.CYC_CLKS(CYC), .HALT_CLKS(HALT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready_in   (ready_in),
    .cpu_a      (cpu_a),
    .cpu_r_nw   (cpu_r_nw),
    .cpu_dout   (cpu_dout),
    .cpu_ready  (cpu_ready),
    .bus_din    (bus_din),
    .bus_a      (bus_a),
    .bus_r_nw   (bus_r_nw),
    .bus_dout   (bus_dout),
    .dma_active (dma_active)
  );

  always #10 clk = ~clk;

  // Memory model: page $02 holds xx^A5; other pages mix in the page number.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA7;
  endfunction

  assign bus_din = mem(bus_a);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  // Monitor state
  bit          mon_en    = 0;
  bit          prev_act  = 0;
  bit          prev_wr   = 0;
  int          dma_len   = 0;
  int          last_len  = 0;
  int          wr_in_dma = 0;
  logic [15:0] rd_addr   = 16'h0000;

  // Sample away from the active edge; pair each DMA write with the read before it.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   is_wr;
      exp_t e;
      check("cpu_ready_eq", cpu_ready, ready_in && !dma_active);
      if (dma_active) begin
        dma_len++;
        if (bus_r_nw) rd_addr = bus_a;
        is_wr = !bus_r_nw && (bus_a == 16'h2004);
        if (is_wr && !prev_wr) begin
          wr_in_dma++;
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rd_addr", rd_addr, e.addr);
            check("wr_data", bus_dout, e.data);
          end
        end
        prev_wr = is_wr;
      end else begin
        if (prev_act) last_len = dma_len;
        dma_len   = 0;
        wr_in_dma = 0;
        prev_wr   = 0;
      end
      prev_act = dma_active;
    end
  end

  task automatic push_page(input logic [7:0] page);
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      e.addr = {page, 8'(i)};
      e.data = mem(e.addr);
      sb.push_back(e);
    end
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    cpu_a    = a;
    cpu_r_nw = rnw;
    cpu_dout = d;
  endtask

  // Four-clock CPU write to $4014; checks start latency and HALT passthrough.
  task automatic trigger(input logic [7:0] page);
    @(posedge clk); #1;
    cpu_drive(16'h4014, 1'b0, page);
    @(negedge clk);
    check("pre_start_dma_active", dma_active, 0);
    @(negedge clk);
    check("start_dma_active", dma_active, 1);
    check("start_cpu_ready", cpu_ready, 0);
    check("halt_bus_a", bus_a, 16'h4014);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    cpu_drive(16'h8000, 1'b1, 8'h00);
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!dma_active) done = 1;
    end
    #1;
    check("dma_done_in_budget", done, 1);
  endtask

  task automatic wait_wr(input int n);
    bit hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk); #1;
      if (wr_in_dma == n) hit = 1;
    end
    check("reach_write_n", hit, 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;
    logic        rdy;
    logic [15:0] e_a;
    logic        e_rnw;
    logic [7:0]  e_d;
    logic        e_ready;
    logic        e_act;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{16'h8000, 1'b1, 8'h00, 1'b1, 16'h8000, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[1] = '{16'h0300, 1'b0, 8'h55, 1'b1, 16'h0300, 1'b0, 8'h55, 1'b1, 1'b0};
    vt[2] = '{16'h4014, 1'b1, 8'h02, 1'b1, 16'h4014, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[3] = '{16'h4015, 1'b0, 8'h02, 1'b1, 16'h4015, 1'b0, 8'h02, 1'b1, 1'b0};
    vt[4] = '{16'h4013, 1'b0, 8'h03, 1'b1, 16'h4013, 1'b0, 8'h03, 1'b1, 1'b0};
    vt[5] = '{16'h2004, 1'b0, 8'h11, 1'b0, 16'h2004, 1'b0, 8'h11, 1'b0, 1'b0};
    vt[6] = '{16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[7] = '{16'hFFFF, 1'b0, 8'hAA, 1'b1, 16'hFFFF, 1'b0, 8'hAA, 1'b1, 1'b0};

    rst      = 1'b1;
    ready_in = 1'b1;
    cpu_drive(16'h8000, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dma_active", dma_active, 0);
    check("rst_cpu_ready", cpu_ready, 1);
    check("rst_bus_a", bus_a, 16'h8000);
    ready_in = 1'b0;
    #1;
    check("rst_cpu_ready_follows", cpu_ready, 0);
    ready_in = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1;

    // Passthrough table
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cpu_drive(vt[i].a, vt[i].rnw, vt[i].d);
      ready_in = vt[i].rdy;
      @(negedge clk);
      check("pt_bus_a", bus_a, vt[i].e_a);
      check("pt_bus_r_nw", bus_r_nw, vt[i].e_rnw);
      check("pt_bus_dout", bus_dout, vt[i].e_d);
      check("pt_cpu_ready", cpu_ready, vt[i].e_ready);
      check("pt_dma_active", dma_active, vt[i].e_act);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    cpu_drive(16'h8000, 1'b1, 8'h00);

    // Basic DMA from page $02
    push_page(8'h02);
    trigger(8'h02);
    wait_done();
    check("basic_stall_len", last_len, DMA_LEN);
    check("basic_sb_drained", sb.size(), 0);

    // Immediate re-trigger, with a forced $4014 hit mid-DMA
    push_page(8'h10);
    trigger(8'h10);
    repeat (100) @(posedge clk);
    #1;
    cpu_drive(16'h4014, 1'b0, 8'h33);
    repeat (8) @(posedge clk);
    #1;
    cpu_drive(16'h8000, 1'b1, 8'h00);
    wait_done();
    check("retrig_stall_len", last_len, DMA_LEN);
    check("retrig_sb_drained", sb.size(), 0);
    begin
      int extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (dma_active) extra++;
      end
      check("no_extra_dma", extra, 0);
    end

    // Page $FF: last read at $FFFF, no wrap into $0000
    push_page(8'hFF);
    trigger(8'hFF);
    wait_done();
    check("pageff_last_rd", rd_addr, 16'hFFFF);
    check("pageff_sb_drained", sb.size(), 0);

    // ready_in low for 7 clocks during the WRITE of byte $40
    push_page(8'h05);
    trigger(8'h05);
    wait_wr(8'h41);
    begin
      logic [15:0] s_a;
      logic        s_rnw;
      logic [7:0]  s_d;
      s_a   = bus_a;
      s_rnw = bus_r_nw;
      s_d   = bus_dout;
      @(posedge clk); #1;
      ready_in = 1'b0;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        check("stall_bus_a", bus_a, s_a);
        check("stall_bus_r_nw", bus_r_nw, s_rnw);
        check("stall_bus_dout", bus_dout, s_d);
        @(posedge clk);
      end
      #1;
      ready_in = 1'b1;
    end
    wait_done();
    check("stall_len", last_len, DMA_LEN + 7);
    check("stall_sb_drained", sb.size(), 0);

    // Reset during byte $80, then restart from $NN00
    push_page(8'h06);
    trigger(8'h06);
    wait_wr(8'h81);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rstmid_dma_active", dma_active, 0);
    check("rstmid_cpu_ready", cpu_ready, 1);
    check("rstmid_bus_a", bus_a, 16'h8000);
    check("rstmid_bus_r_nw", bus_r_nw, 1);
    push_page(8'h07);
    trigger(8'h07);
    wait_done();
    check("restart_stall_len", last_len, DMA_LEN);
    check("restart_sb_drained", sb.size(), 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
